// File: rtl/dsp_chain_pkg.sv
// Shared definitions for the fp16 sum-of-products chain operand feeder:
// collection FSM states, operand field positions and the fp16 zero constant.
package dsp_chain_pkg;

  localparam int unsigned FP16_W    = 16;
  localparam int unsigned OPS_W     = 4 * FP16_W;
  localparam int unsigned TOP_A_LSB = 48;
  localparam int unsigned TOP_B_LSB = 32;
  localparam int unsigned BOT_A_LSB = 16;
  localparam int unsigned BOT_B_LSB = 0;

  localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HAVE1 = 2'd1,
    HAVE2 = 2'd2
  } fill_state_e;

  // Assemble one stage operand word from its four fp16 fields.
  function automatic logic [OPS_W-1:0] pack_ops(
    input logic [FP16_W-1:0] top_a,
    input logic [FP16_W-1:0] top_b,
    input logic [FP16_W-1:0] bot_a,
    input logic [FP16_W-1:0] bot_b
  );
    logic [OPS_W-1:0] w;
    w = '0;
    w[TOP_A_LSB +: FP16_W] = top_a;
    w[TOP_B_LSB +: FP16_W] = top_b;
    w[BOT_A_LSB +: FP16_W] = bot_a;
    w[BOT_B_LSB +: FP16_W] = bot_b;
    return w;
  endfunction

  // Padding beat used for missing stages of a flushed group.
  localparam logic [OPS_W-1:0] ZERO_BEAT = pack_ops(FP16_ZERO, FP16_ZERO, FP16_ZERO, FP16_ZERO);

endpackage

// File: rtl/dsp_chain_skew_delay.sv
// Fixed-depth valid+data delay line. With ZERO_IDLE the data lane reads zero
// whenever its valid is low; otherwise each tap holds the last valid data.
module dsp_chain_skew_delay #(
  parameter int unsigned DEPTH     = 1,
  parameter int unsigned WIDTH     = 64,
  parameter bit          ZERO_IDLE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic [DEPTH-1:0] r_valid;
  logic [WIDTH-1:0] r_data [DEPTH];

  // Shift valid every cycle; data moves only with valid unless idle-zeroing.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_data[i] <= '0;
      end
    end else begin
      r_valid[0] <= i_valid;
      if (ZERO_IDLE || i_valid) begin
        r_data[0] <= i_valid ? i_data : '0;
      end
      for (int i = 1; i < int'(DEPTH); i++) begin
        r_valid[i] <= r_valid[i-1];
        if (ZERO_IDLE || r_valid[i-1]) begin
          r_data[i] <= r_valid[i-1] ? r_data[i-1] : '0;
        end
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_data  = r_data[DEPTH-1];

endmodule

// File: rtl/dsp_chain_operand_feeder.sv
// Collects three operand beats per group and issues them to a cascaded fp16
// sum-of-products chain with one-cycle skew per stage, plus a result-valid
// pulse CHAIN_LAT cycles after the last stage. Flush pads a partial group.
// Build option: DSP_CHAIN_FEEDER_ZERO_IDLE_EN zeroes stage operands while idle.
module dsp_chain_operand_feeder
  import dsp_chain_pkg::*;
#(
  parameter int unsigned CHAIN_LAT  = 4,
  parameter int unsigned NUM_STAGES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPS_W-1:0]  in_data,
  input  logic              flush,
  output logic [OPS_W-1:0]  stg1_ops,
  output logic [OPS_W-1:0]  stg2_ops,
  output logic [OPS_W-1:0]  stg3_ops,
  output logic [2:0]        stg_valid,
  output logic              result_valid,
  output logic [15:0]       group_count
);

`ifdef DSP_CHAIN_FEEDER_ZERO_IDLE_EN
  localparam bit ZERO_IDLE = 1'b1;
`else
  localparam bit ZERO_IDLE = 1'b0;
`endif

  localparam int unsigned RES_DEPTH = NUM_STAGES + CHAIN_LAT;

  fill_state_e      r_state;
  fill_state_e      w_state_nxt;
  logic [OPS_W-1:0] r_beat0;
  logic [OPS_W-1:0] r_beat1;
  logic [15:0]      r_group_count;

  logic             w_accept;
  logic             w_issue;
  logic             w_load0;
  logic             w_load1;
  logic [OPS_W-1:0] w_g0;
  logic [OPS_W-1:0] w_g1;
  logic [OPS_W-1:0] w_g2;
  logic             w_v1;
  logic             w_v2;
  logic             w_v3;
  logic             w_res_valid;
  logic             w_res_mark;

  // Never back-pressure outside reset.
  assign in_ready = ~reset;
  assign w_accept = in_valid & ~reset;

  // Collection state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next collection state: third beat or any flush with data returns to EMPTY.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY: if (w_accept && !flush) w_state_nxt = HAVE1;
      HAVE1: begin
        if (flush)         w_state_nxt = EMPTY;
        else if (w_accept) w_state_nxt = HAVE2;
      end
      HAVE2: if (flush || w_accept) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  // Group assembly: current beat joins before any zero padding.
  always_comb begin
    w_issue = 1'b0;
    w_load0 = 1'b0;
    w_load1 = 1'b0;
    w_g0    = ZERO_BEAT;
    w_g1    = ZERO_BEAT;
    w_g2    = ZERO_BEAT;
    case (r_state)
      EMPTY: begin
        w_g0    = in_data;
        w_issue = w_accept & flush;
        w_load0 = w_accept & ~flush;
      end
      HAVE1: begin
        w_g0    = r_beat0;
        w_g1    = w_accept ? in_data : ZERO_BEAT;
        w_issue = flush & ~reset;
        w_load1 = w_accept & ~flush;
      end
      HAVE2: begin
        w_g0    = r_beat0;
        w_g1    = r_beat1;
        w_g2    = w_accept ? in_data : ZERO_BEAT;
        w_issue = (flush & ~reset) | w_accept;
      end
      default: begin
        w_issue = 1'b0;
      end
    endcase
  end

  // Hold the first two beats of a group until it completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_beat0 <= '0;
      r_beat1 <= '0;
    end else begin
      if (w_load0) r_beat0 <= in_data;
      if (w_load1) r_beat1 <= in_data;
    end
  end

  // Issued-group counter, wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_group_count <= '0;
    end else if (w_issue) begin
      r_group_count <= r_group_count + 16'd1;
    end
  end

  assign group_count = r_group_count;

  dsp_chain_skew_delay #(.DEPTH(1), .WIDTH(OPS_W), .ZERO_IDLE(ZERO_IDLE)) u_skew_stg1 (
    .clk     (clk),
    .reset   (reset),
    .i_valid (w_issue),
    .i_data  (w_g0),
    .o_valid (w_v1),
    .o_data  (stg1_ops)
  );

  dsp_chain_skew_delay #(.DEPTH(2), .WIDTH(OPS_W), .ZERO_IDLE(ZERO_IDLE)) u_skew_stg2 (
    .clk     (clk),
    .reset   (reset),
    .i_valid (w_issue),
    .i_data  (w_g1),
    .o_valid (w_v2),
    .o_data  (stg2_ops)
  );

  dsp_chain_skew_delay #(.DEPTH(NUM_STAGES), .WIDTH(OPS_W), .ZERO_IDLE(ZERO_IDLE)) u_skew_stg3 (
    .clk     (clk),
    .reset   (reset),
    .i_valid (w_issue),
    .i_data  (w_g2),
    .o_valid (w_v3),
    .o_data  (stg3_ops)
  );

  // Result-valid line; its single data bit mirrors valid (idle-zeroed).
  dsp_chain_skew_delay #(.DEPTH(RES_DEPTH), .WIDTH(1), .ZERO_IDLE(1'b1)) u_skew_result (
    .clk     (clk),
    .reset   (reset),
    .i_valid (w_issue),
    .i_data  (w_issue),
    .o_valid (w_res_valid),
    .o_data  (w_res_mark)
  );

  assign stg_valid    = {w_v3, w_v2, w_v1};
  assign result_valid = w_res_valid & w_res_mark;

endmodule

// File: tb/tb_dsp_chain_operand_feeder.sv
// Randomized + directed bench for dsp_chain_operand_feeder against a
// queue/event-map reference model of group collection and skewed issue.
module tb_dsp_chain_operand_feeder;

  localparam int unsigned CHAIN_LAT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        flush;
  logic [63:0] stg1_ops;
  logic [63:0] stg2_ops;
  logic [63:0] stg3_ops;
  logic [2:0]  stg_valid;
  logic        result_valid;
  logic [15:0] group_count;

  always #5 clk = ~clk;

  dsp_chain_operand_feeder #(.CHAIN_LAT(CHAIN_LAT), .NUM_STAGES(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .flush        (flush),
    .stg1_ops     (stg1_ops),
    .stg2_ops     (stg2_ops),
    .stg3_ops     (stg3_ops),
    .stg_valid    (stg_valid),
    .result_valid (result_valid),
    .group_count  (group_count)
  );

`ifdef DSP_CHAIN_FEEDER_ZERO_IDLE_EN
  localparam bit ZERO_IDLE = 1'b1;
`else
  localparam bit ZERO_IDLE = 1'b0;
`endif

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: pending beats and per-cycle expected events.
  logic [63:0] pend[$];
  logic [63:0] ev1[int];
  logic [63:0] ev2[int];
  logic [63:0] ev3[int];
  bit          evr[int];
  logic [15:0] m_count = 16'h0;
  logic [63:0] last1 = 64'h0;
  logic [63:0] last2 = 64'h0;
  logic [63:0] last3 = 64'h0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_cycle(input bit v, input logic [63:0] d, input bit f, input bit r, input int cur);
    if (r) begin
      pend.delete();
      ev1.delete(); ev2.delete(); ev3.delete(); evr.delete();
      m_count = 16'h0;
      last1 = 64'h0; last2 = 64'h0; last3 = 64'h0;
    end else begin
      if (v) pend.push_back(d);
      if (pend.size() == 3 || (f && pend.size() > 0)) begin
        while (pend.size() < 3) pend.push_back(64'h0);
        ev1[cur + 1] = pend[0];
        ev2[cur + 2] = pend[1];
        ev3[cur + 3] = pend[2];
        evr[cur + 3 + int'(CHAIN_LAT)] = 1'b1;
        m_count = m_count + 16'd1;
        pend.delete();
      end
    end
  endtask

  task automatic check_outputs(input int c);
    logic [2:0]  ev;
    logic [63:0] e1, e2, e3;
    ev = 3'b000;
    if (ev1.exists(c)) begin ev[0] = 1'b1; last1 = ev1[c]; ev1.delete(c); end
    if (ev2.exists(c)) begin ev[1] = 1'b1; last2 = ev2[c]; ev2.delete(c); end
    if (ev3.exists(c)) begin ev[2] = 1'b1; last3 = ev3[c]; ev3.delete(c); end
    e1 = (ZERO_IDLE && !ev[0]) ? 64'h0 : last1;
    e2 = (ZERO_IDLE && !ev[1]) ? 64'h0 : last2;
    e3 = (ZERO_IDLE && !ev[2]) ? 64'h0 : last3;
    check_eq("stg_valid", 64'(stg_valid), 64'(ev));
    check_eq("stg1_ops", stg1_ops, e1);
    check_eq("stg2_ops", stg2_ops, e2);
    check_eq("stg3_ops", stg3_ops, e3);
    check_eq("result_valid", 64'(result_valid), 64'(evr.exists(c)));
    if (evr.exists(c)) evr.delete(c);
    check_eq("group_count", 64'(group_count), 64'(m_count));
  endtask

  task automatic step(input bit v, input logic [63:0] d, input bit f, input bit r);
    @(negedge clk);
    in_valid = v;
    in_data  = v ? d : {$urandom, $urandom};
    flush    = f;
    reset    = r;
    #1;
    check_eq("in_ready", 64'(in_ready), 64'(!r));
    model_cycle(v, d, f, r, cyc);
    @(posedge clk);
    cyc++;
    #1;
    check_outputs(cyc);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 64'h0, 1'b0, 1'b0);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 64'h0;
    flush    = 1'b0;

    for (int i = 0; i < 3; i++) step(1'b0, 64'h0, 1'b0, 1'b1);

    // Three beats A,B,C form one skewed group.
    step(1'b1, 64'hAAAA_0001_AAAA_0002, 1'b0, 1'b0);
    step(1'b1, 64'hBBBB_0003_BBBB_0004, 1'b0, 1'b0);
    step(1'b1, 64'hCCCC_0005_CCCC_0006, 1'b0, 1'b0);
    idle(8);
    check_eq("one_group_count", 64'(group_count), 64'd1);

    // Six back-to-back beats: two overlapping groups.
    for (int i = 0; i < 6; i++) step(1'b1, rnd64(), 1'b0, 1'b0);
    idle(10);

    // Single beat then flush with no beat.
    step(1'b1, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0);
    idle(6);

    // Flush with second beat; flush in EMPTY; flush with third beat; flush with beat in EMPTY.
    step(1'b1, rnd64(), 1'b0, 1'b0);
    step(1'b1, rnd64(), 1'b1, 1'b0);
    idle(6);
    step(1'b0, 64'h0, 1'b1, 1'b0);
    idle(4);
    step(1'b1, rnd64(), 1'b0, 1'b0);
    step(1'b1, rnd64(), 1'b0, 1'b0);
    step(1'b1, rnd64(), 1'b1, 1'b0);
    step(1'b1, rnd64(), 1'b1, 1'b0);
    idle(8);

    // Reset one cycle after a group completes kills all in-flight pulses.
    step(1'b1, rnd64(), 1'b0, 1'b0);
    step(1'b1, rnd64(), 1'b0, 1'b0);
    step(1'b1, rnd64(), 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b0, 1'b1);
    check_eq("post_reset_valid", 64'(stg_valid), 64'd0);
    check_eq("post_reset_ops", stg1_ops | stg2_ops | stg3_ops, 64'd0);
    idle(10);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom % 4) != 0, rnd64(), ($urandom % 6) == 0, ($urandom % 200) == 0);
    end
    idle(10);

    // Preload 65535 groups, then one more wraps the counter.
    step(1'b0, 64'h0, 1'b0, 1'b1);
    for (int i = 0; i < 65535; i++) step(1'b1, rnd64(), 1'b1, 1'b0);
    check_eq("count_full", 64'(group_count), 64'hFFFF);
    step(1'b1, rnd64(), 1'b1, 1'b0);
    check_eq("count_wrap", 64'(group_count), 64'h0);
    idle(10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
